seq_divider: RTL and testbench

- Multicycle signed integer divider that produces the HI/LO operands for the datapath's HI and LO registers.
- Sits directly downstream of the A/B operand registers and upstream of HI/LO.
- The control unit pulses `start`, waits for `ready`, then writes HI/LO, or takes the divide-by-zero exception when `div_zero` is set.
- Algorithm: restoring shift-subtract on magnitudes, one quotient bit per cycle, sign fix-up at the end.

---
 rtl/seq_divider_pkg.sv | 16 +
 rtl/seq_div_step.sv | 35 +++
 rtl/seq_divider.sv | 131 +++++++++++++
 tb/tb_seq_divider.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_divider_pkg.sv
// Shared types and defaults for the sequential signed divider.
// Contents: FSM state encoding and the default operand width.
// Imported by seq_divider and seq_div_step.
package seq_divider_pkg;

   localparam int DIV_WIDTH_DEFAULT = 32;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      PREP = 3'd1,
      ITER = 3'd2,
      FIX  = 3'd3,
      DONE = 3'd4
   } state_t;

endpackage

// File: rtl/seq_div_step.sv
// One restoring shift-subtract step on magnitudes (purely combinational).
// Ports: r_in/q_in = current partial remainder and quotient shift register,
//        b_mag = divisor magnitude; r_out/q_out = values after the step.
module seq_div_step
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
   input  logic [WIDTH:0]   r_in,
   input  logic [WIDTH-1:0] q_in,
   input  logic [WIDTH-1:0] b_mag,
   output logic [WIDTH:0]   r_out,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH:0]   r_sh;
   logic [WIDTH-1:0] q_sh;
   logic [WIDTH:0]   b_ext;

   always_comb begin
      // {R,Q} shifted left by one; the MSB of Q enters the bottom of R.
      r_sh  = (r_in << 1) | {{WIDTH{1'b0}}, q_in[WIDTH-1]};
      q_sh  = q_in << 1;
      // R is one bit wider than |b| so the compare stays exact for
      // magnitudes up to 2^WIDTH-1.
      b_ext = {1'b0, b_mag};
      r_out = r_sh;
      q_out = q_sh;
      if (r_sh >= b_ext) begin
         r_out = r_sh - b_ext;
         q_out = q_sh | {{(WIDTH-1){1'b0}}, 1'b1};
      end
   end

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed divider producing HI (remainder) and LO (quotient).
// Ports: clk, reset (async active-high), start/a/b request, hi/lo results,
//        ready (1-cycle done pulse), div_zero (with ready when b==0), busy.
// Build option SEQ_DIVIDER_UNSIGNED_EN adds is_unsigned (DIVU) sampled with start.
module seq_divider
   import seq_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH_DEFAULT,
   parameter int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
`ifdef SEQ_DIVIDER_UNSIGNED_EN
   input  logic             is_unsigned,
`endif
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             ready,
   output logic             div_zero,
   output logic             busy
);

   state_t           state;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   r;
   logic [WIDTH-1:0] q;
   logic [CNT_W-1:0] cnt;
   logic             sign_q;
   logic             sign_r;

   logic             uns;
   logic [WIDTH-1:0] a_abs;
   logic [WIDTH-1:0] b_abs;
   logic [WIDTH:0]   r_next;
   logic [WIDTH-1:0] q_next;
   logic [WIDTH-1:0] r_low;

`ifdef SEQ_DIVIDER_UNSIGNED_EN
   assign uns = is_unsigned;
`else
   assign uns = 1'b0;
`endif

   // |x| of the most negative value is itself, which is the correct
   // unsigned magnitude; unsigned operations use the raw operands.
   always_comb begin
      a_abs = (!uns && a[WIDTH-1]) ? -a : a;
      b_abs = (!uns && b[WIDTH-1]) ? -b : b;
   end

   assign r_low = r[WIDTH-1:0];

   seq_div_step #(.WIDTH(WIDTH)) u_step (
      .r_in  (r),
      .q_in  (q),
      .b_mag (b_mag),
      .r_out (r_next),
      .q_out (q_next)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hi       <= '0;
         lo       <= '0;
         ready    <= 1'b0;
         div_zero <= 1'b0;
         busy     <= 1'b0;
         a_mag    <= '0;
         b_mag    <= '0;
         r        <= '0;
         q        <= '0;
         cnt      <= '0;
         sign_q   <= 1'b0;
         sign_r   <= 1'b0;
      end else begin
         ready    <= 1'b0;
         div_zero <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (b == '0) begin
                     // Divide-by-zero skips the datapath; hi/lo untouched.
                     ready    <= 1'b1;
                     div_zero <= 1'b1;
                     state    <= DONE;
                  end else begin
                     a_mag  <= a_abs;
                     b_mag  <= b_abs;
                     sign_q <= !uns && (a[WIDTH-1] ^ b[WIDTH-1]);
                     sign_r <= !uns && a[WIDTH-1];
                     busy   <= 1'b1;
                     state  <= PREP;
                  end
               end
            end
            PREP: begin
               r     <= '0;
               q     <= a_mag;
               cnt   <= CNT_W'(WIDTH);
               state <= ITER;
            end
            ITER: begin
               r   <= r_next;
               q   <= q_next;
               cnt <= cnt - CNT_W'(1);
               if (cnt == CNT_W'(1)) state <= FIX;
            end
            FIX: begin
               // Remainder takes the dividend's sign; -MIN/-1 wraps silently.
               lo    <= sign_q ? -q : q;
               hi    <= sign_r ? -r_low : r_low;
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= DONE;
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic         ready;
   logic         div_zero;
   logic         busy;
`ifdef SEQ_DIVIDER_UNSIGNED_EN
   logic         is_uns = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   seq_divider #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      .is_unsigned (is_uns),
`endif
      .a           (a),
      .b           (b),
      .hi          (hi),
      .lo          (lo),
      .ready       (ready),
      .div_zero    (div_zero),
      .busy        (busy)
   );

   // Issues one request and counts negedges until ready (0 = timed out).
   // Operands are scrambled right after the accepting edge.
   task automatic run_div(input logic [W-1:0] av, input logic [W-1:0] bv,
                          output int lat, output int busy_cnt, output logic dz);
      @(negedge clk);
      start = 1'b1; a = av; b = bv;
      lat = 0; busy_cnt = 0; dz = 1'b0;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         if (i == 1) begin
            start = 1'b0; a = 32'hDEAD_BEEF; b = 32'h0;
         end
         if (busy) busy_cnt++;
         if (ready) begin
            lat = i; dz = div_zero;
            break;
         end
      end
   endtask

   task automatic test_reset();
      @(negedge clk); reset = 1'b1;
      @(negedge clk);
      checks++; if (hi !== 32'h0)     begin failures++; $display("FAIL reset_hi got=%h exp=0", hi); end
      checks++; if (lo !== 32'h0)     begin failures++; $display("FAIL reset_lo got=%h exp=0", lo); end
      checks++; if ({ready, div_zero, busy} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {ready, div_zero, busy}); end
      reset = 1'b0;
   endtask

   task automatic check_div(input string nm, input logic [W-1:0] av, input logic [W-1:0] bv,
                            input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
      int lat, bc; logic dz;
      run_div(av, bv, lat, bc, dz);
      checks++; if (lat !== 35)     begin failures++; $display("FAIL %s_latency got=%0d exp=35", nm, lat); end
      checks++; if (lo !== exp_lo)  begin failures++; $display("FAIL %s_lo got=%h exp=%h", nm, lo, exp_lo); end
      checks++; if (hi !== exp_hi)  begin failures++; $display("FAIL %s_hi got=%h exp=%h", nm, hi, exp_hi); end
      checks++; if (dz !== 1'b0)    begin failures++; $display("FAIL %s_dz got=%b exp=0", nm, dz); end
      checks++; if (bc !== 34)      begin failures++; $display("FAIL %s_busy_cycles got=%0d exp=34", nm, bc); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL %s_busy_at_ready got=%b exp=0", nm, busy); end
   endtask

   task automatic test_signed();
      check_div("pos_pos", 32'd100, 32'd7, 32'd14, 32'd2);
      check_div("neg_pos", 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE);
      check_div("pos_neg", 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2);
   endtask

   task automatic test_div_zero();
      int lat, bc; logic dz;
      check_div("pre_dz", 32'd100, 32'd7, 32'd14, 32'd2);
      run_div(32'd5, 32'd0, lat, bc, dz);
      checks++; if (lat !== 1)       begin failures++; $display("FAIL dz_latency got=%0d exp=1", lat); end
      checks++; if (dz !== 1'b1)     begin failures++; $display("FAIL dz_flag got=%b exp=1", dz); end
      checks++; if (lo !== 32'd14)   begin failures++; $display("FAIL dz_lo_kept got=%h exp=e", lo); end
      checks++; if (hi !== 32'd2)    begin failures++; $display("FAIL dz_hi_kept got=%h exp=2", hi); end
      checks++; if (bc !== 0)        begin failures++; $display("FAIL dz_busy got=%0d exp=0", bc); end
      @(negedge clk);
      checks++; if ({ready, div_zero} !== 2'b00) begin failures++; $display("FAIL dz_pulse_width got=%b exp=00", {ready, div_zero}); end
   endtask

   task automatic test_overflow();
      check_div("min_by_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0);
      check_div("min_by_min", 32'h8000_0000, 32'h8000_0000, 32'd1, 32'h0);
   endtask

   task automatic test_ignored_start();
      int lat = 0;
      @(negedge clk);
      start = 1'b1; a = 32'd50; b = 32'd3;
      for (int i = 1; i <= 100; i++) begin
         @(negedge clk);
         start = (i == 10);
         if (i == 10) begin a = 32'd1000; b = 32'd1; end
         if (ready) begin lat = i; break; end
      end
      start = 1'b0;
      checks++; if (lat !== 35)     begin failures++; $display("FAIL ign_latency got=%0d exp=35", lat); end
      checks++; if (lo !== 32'd16)  begin failures++; $display("FAIL ign_lo got=%h exp=10", lo); end
      checks++; if (hi !== 32'd2)   begin failures++; $display("FAIL ign_hi got=%h exp=2", hi); end
      repeat (3) begin
         @(negedge clk);
         checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ign_no_queue got=%b exp=0", ready); end
      end
   endtask

   task automatic test_reset_abort();
      int seen = 0;
      @(negedge clk);
      start = 1'b1; a = 32'd9; b = 32'd2;
      @(negedge clk); start = 1'b0;
      repeat (19) begin @(negedge clk); if (ready) seen++; end
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (40) begin @(negedge clk); if (ready) seen++; end
      checks++; if (seen !== 0)     begin failures++; $display("FAIL abort_ready got=%0d exp=0", seen); end
      checks++; if (lo !== 32'h0)   begin failures++; $display("FAIL abort_lo got=%h exp=0", lo); end
      checks++; if (hi !== 32'h0)   begin failures++; $display("FAIL abort_hi got=%h exp=0", hi); end
      checks++; if (busy !== 1'b0)  begin failures++; $display("FAIL abort_busy got=%b exp=0", busy); end
      check_div("after_abort", 32'd9, 32'd2, 32'd4, 32'd1);
   endtask

   task automatic test_back_to_back();
      int first = 0, second = 0;
      @(negedge clk);
      start = 1'b1; a = 32'd20; b = 32'd6;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (ready && first == 0) begin
            first = i;
            checks++; if (lo !== 32'd3 || hi !== 32'd2) begin failures++; $display("FAIL b2b_first got=%h/%h exp=3/2", lo, hi); end
            a = 32'd45; b = 32'd7;
         end else if (ready) begin
            second = i;
            start = 1'b0;
            break;
         end
      end
      start = 1'b0;
      checks++; if (first !== 35)        begin failures++; $display("FAIL b2b_lat1 got=%0d exp=35", first); end
      checks++; if (second - first !== 36) begin failures++; $display("FAIL b2b_gap got=%0d exp=36", second - first); end
      checks++; if (lo !== 32'd6)        begin failures++; $display("FAIL b2b_lo got=%h exp=6", lo); end
      checks++; if (hi !== 32'd3)        begin failures++; $display("FAIL b2b_hi got=%h exp=3", hi); end
      @(negedge clk);
   endtask

`ifdef SEQ_DIVIDER_UNSIGNED_EN
   task automatic test_unsigned();
      is_uns = 1'b1;
      check_div("divu", 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 32'd1);
      is_uns = 1'b0;
      check_div("div_m1_2", 32'hFFFF_FFFF, 32'd2, 32'h0, 32'hFFFF_FFFF);
   endtask
`endif

   initial begin
      test_reset();
      test_signed();
      test_div_zero();
      test_overflow();
      test_ignored_start();
      test_reset_abort();
      test_back_to_back();
`ifdef SEQ_DIVIDER_UNSIGNED_EN
      test_unsigned();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
